// File: rtl/pair_sort_engine_if.sv
//============================================================================
// pair_sort_engine_if : input/output word streams and busy status for the
//                       pair_sort_engine coprocessor
// Revision: 1.0
//============================================================================
`default_nettype none

interface pair_sort_engine_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/pair_sort_engine.sv
//============================================================================
// pair_sort_engine : loads DEPTH words, sorts them with an odd-even
//                    transposition network (one pass per clock), drains them
// Revision: 1.0
//============================================================================
`default_nettype none

module pair_sort_engine #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int SIGNED  = 0,
  parameter int DESCEND = 0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pair_sort_engine_if.slave bus
);

  localparam int              CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DEPTH - 1);
  // Flipping the sign bit turns a two's-complement compare into an unsigned one
  localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] next_mem [DEPTH];
  logic [CW-1:0]    load_cnt;
  logic [CW-1:0]    drain_cnt;
  logic [CW-1:0]    pass_cnt;
  logic [DEPTH-2:0] swap;

  // Even passes pair (0,1),(2,3)...; odd passes pair (1,2),(3,4)...
  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_pair
    logic [WIDTH-1:0] key_lo;
    logic [WIDTH-1:0] key_hi;
    logic             active;

    assign key_lo = mem[i]     ^ SIGN_FLIP;
    assign key_hi = mem[i + 1] ^ SIGN_FLIP;
    assign active = (pass_cnt[0] == 1'(i % 2));

    if (DESCEND != 0) begin : g_desc
      assign swap[i] = active && (key_lo < key_hi);
    end else begin : g_asc
      assign swap[i] = active && (key_lo > key_hi);
    end
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_next
    if (j == 0) begin : g_first
      assign next_mem[j] = swap[0] ? mem[1] : mem[0];
    end else if (j == DEPTH - 1) begin : g_last
      assign next_mem[j] = swap[j - 1] ? mem[j - 1] : mem[j];
    end else begin : g_mid
      assign next_mem[j] = swap[j - 1] ? mem[j - 1] :
                           swap[j]     ? mem[j + 1] : mem[j];
    end
  end

  assign bus.out_data = bus.out_valid ? mem[drain_cnt] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOAD;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      load_cnt      <= '0;
      drain_cnt     <= '0;
      pass_cnt      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid && bus.in_ready) begin
            mem[load_cnt] <= bus.in_data;
            if (load_cnt == LAST) begin
              load_cnt     <= '0;
              pass_cnt     <= '0;
              bus.in_ready <= 1'b0;
              bus.busy     <= 1'b1;
              state        <= SORT;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end

        SORT: begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= next_mem[i];
          end
          if (pass_cnt == LAST) begin
            pass_cnt      <= '0;
            bus.out_valid <= 1'b1;
            state         <= DRAIN;
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
          end
        end

        DRAIN: begin
          if (bus.out_ready) begin
            if (drain_cnt == LAST) begin
              drain_cnt     <= '0;
              bus.out_valid <= 1'b0;
              bus.in_ready  <= 1'b1;
              bus.busy      <= 1'b0;
              state         <= LOAD;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end

        default: begin
          state         <= LOAD;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pair_sort_engine.sv
//============================================================================
// tb_pair_sort_engine : scoreboard bench for three pair_sort_engine variants
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_pair_sort_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_valid;
  logic [7:0] in_data [3];
  logic [2:0] out_ready;
  logic [2:0] in_ready_w;
  logic [2:0] out_valid_w;
  logic [2:0] busy_w;
  logic [7:0] out_data_w [3];

  typedef struct packed {
    logic [1:0] inst;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // Instance 0: unsigned ascending, 1: unsigned descending, 2: signed ascending
  for (genvar g = 0; g < 3; g++) begin : g_dut
    pair_sort_engine_if #(.WIDTH(8)) bus ();

    assign bus.in_valid   = in_valid[g];
    assign bus.in_data    = in_data[g];
    assign bus.out_ready  = out_ready[g];
    assign in_ready_w[g]  = bus.in_ready;
    assign out_valid_w[g] = bus.out_valid;
    assign busy_w[g]      = bus.busy;
    assign out_data_w[g]  = bus.out_data;

    pair_sort_engine #(
      .WIDTH  (8),
      .DEPTH  (4),
      .SIGNED ((g == 2) ? 1 : 0),
      .DESCEND((g == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst && out_valid_w[k] && out_ready[k]) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_out: inst %0d gave %0d with nothing expected", k, out_data_w[k]);
          end else begin
            e = exp_q.pop_front();
            check("out_inst", k, int'(e.inst));
            check("out_data", int'(out_data_w[k]), int'(e.data));
          end
        end
      end
    end
  endtask

  task automatic expect4(input int k, input int e0, input int e1, input int e2, input int e3);
    exp_q.push_back('{inst: 2'(k), data: 8'(e0)});
    exp_q.push_back('{inst: 2'(k), data: 8'(e1)});
    exp_q.push_back('{inst: 2'(k), data: 8'(e2)});
    exp_q.push_back('{inst: 2'(k), data: 8'(e3)});
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic push_word(input int k, input int w);
    int n = 0;
    while (!in_ready_w[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", int'(in_ready_w[k]), 1);
    in_valid[k] = 1'b1;
    in_data[k]  = 8'(w);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic load4(input int k, input int w0, input int w1, input int w2, input int w3);
    push_word(k, w0);
    push_word(k, w1);
    push_word(k, w2);
    push_word(k, w3);
  endtask

  task automatic wait_drained(input int k);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_done", exp_q.size(), 0);
    check("post_in_ready", int'(in_ready_w[k]), 1);
    check("post_out_valid", int'(out_valid_w[k]), 0);
    check("post_busy", int'(busy_w[k]), 0);
  endtask

  initial begin
    int n;
    in_valid  = '0;
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) in_data[k] = '0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", int'(in_ready_w[k]), 1);
      check("rst_out_valid", int'(out_valid_w[k]), 0);
      check("rst_busy", int'(busy_w[k]), 0);
      check("rst_out_data", int'(out_data_w[k]), 0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned ascending with first-output latency
    expect4(0, 25, 67, 111, 147);
    load4(0, 67, 111, 147, 25);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_w[0] && n < 20);
    check("latency", n, 5);
    wait_drained(0);

    // Descending
    expect4(1, 154, 89, 40, 28);
    load4(1, 89, 28, 40, 154);
    wait_drained(1);

    // Signed vs unsigned on the same words
    expect4(2, 128, 154, 245, 120);
    load4(2, 245, 128, 154, 120);
    wait_drained(2);
    expect4(0, 120, 128, 154, 245);
    load4(0, 245, 128, 154, 120);
    wait_drained(0);

    // Equal words
    expect4(0, 139, 152, 152, 223);
    load4(0, 152, 223, 152, 139);
    wait_drained(0);

    // Input pulses during SORT are refused; output backpressure holds data
    expect4(0, 3, 50, 99, 200);
    out_ready[0] = 1'b0;
    load4(0, 200, 3, 99, 50);
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'hEE;
      check("sort_in_ready", int'(in_ready_w[0]), 0);
      check("sort_busy", int'(busy_w[0]), 1);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid_w[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", int'(out_valid_w[0]), 1);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_data", int'(out_data_w[0]), 50);
      check("bp_hold_valid", int'(out_valid_w[0]), 1);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    wait_drained(0);

    // Reset mid-SORT discards the batch
    load4(0, 10, 20, 30, 40);
    @(posedge clk); #1;
    check("pre_rst_busy", int'(busy_w[0]), 1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", int'(out_valid_w[0]), 0);
    check("arst_in_ready", int'(in_ready_w[0]), 1);
    check("arst_busy", int'(busy_w[0]), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    expect4(0, 28, 114, 233, 242);
    load4(0, 242, 114, 233, 28);
    wait_drained(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
